// File: rtl/flp_adder_align_swap_pkg.sv
// Shared constants and types for the floating-point adder align/swap front end.
// Default widths describe IEEE-754 single precision.
package flp_adder_align_swap_pkg;

  localparam int EXPONENT_BITS_DEF    = 8;
  localparam int SIGNIFICANT_BITS_DEF = 23;

  // Which input operand ends up as the larger-magnitude "b" operand.
  typedef enum logic {
    SEL_B_LARGER = 1'b0,
    SEL_A_LARGER = 1'b1
  } swap_sel_e;

endpackage

// File: rtl/flp_adder_align_swap_shifter.sv
// Combinational right barrel shift of the smaller significand, reporting the
// most significant bit shifted out and whether the operand vanishes entirely.
module flp_adder_align_swap_shifter #(
  parameter int SIG_W       = 24,
  parameter int SHIFT_W     = 8,
  parameter int SHIFT_LIMIT = 25
) (
  input  logic [SIG_W-1:0]   sig_in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               force_zero,
  output logic [SIG_W-1:0]   sig_out,
  output logic               bit_shifted_out,
  output logic               underflow
);

  logic [31:0] shift_ext;

  always_comb begin
    shift_ext       = 32'(shift);
    underflow       = force_zero || (shift_ext >= 32'(SHIFT_LIMIT));
    sig_out         = sig_in >> shift;
    bit_shifted_out = 1'b0;
    // Bit (shift-1) of the input is the last one to fall off the right end.
    for (int i = 0; i < SIG_W; i++) begin
      if (shift_ext == 32'(i + 1)) begin
        bit_shifted_out = sig_in[i];
      end
    end
    if (underflow) begin
      sig_out         = '0;
      bit_shifted_out = 1'b0;
    end
  end

endmodule

// File: rtl/flp_adder_align_swap.sv
// Front half of the FP adder: order operands by magnitude and right-align the
// smaller significand to the larger exponent. Two registered stages, no stall.
module flp_adder_align_swap
  import flp_adder_align_swap_pkg::*;
#(
  parameter int EXPONENT_BITS    = EXPONENT_BITS_DEF,
  parameter int SIGNIFICANT_BITS = SIGNIFICANT_BITS_DEF,
  parameter int OVERALL_BITS     = 1 + EXPONENT_BITS + SIGNIFICANT_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OVERALL_BITS-1:0]   operand_a,
  input  logic [OVERALL_BITS-1:0]   operand_b,
  input  logic                      data_valid,
  output logic                      sign_result_2DP,
  output logic                      data_valid_2DP,
  output logic                      signs_equal_2DP,
  output logic [EXPONENT_BITS-1:0]  exponent_b_2DP,
  output logic [SIGNIFICANT_BITS:0] significant_b_2DP,
  output logic [SIGNIFICANT_BITS:0] denorm_significant_a_2DP,
  output logic                      bit_shifted_out_2DP,
  output logic                      denorm_underflow_2DP
);

  localparam int E           = EXPONENT_BITS;
  localparam int S           = SIGNIFICANT_BITS;
  localparam int SHIFT_LIMIT = SIGNIFICANT_BITS + 2;

  // Unpacked fields and stage-1 combinational results
  logic            sign_a, sign_b;
  logic [E-1:0]    exp_a, exp_b;
  logic [S-1:0]    man_a, man_b;
  logic [E+S-1:0]  mag_a, mag_b;
  swap_sel_e       swap_sel;
  logic [E-1:0]    exp_small;

  // Stage-1 registers
  logic [S:0]      s1_sig_small_d, s1_sig_small_q;
  logic [S:0]      s1_sig_big_d,   s1_sig_big_q;
  logic [E-1:0]    s1_exp_big_d,   s1_exp_big_q;
  logic [E-1:0]    s1_shift_d,     s1_shift_q;
  logic            s1_sign_small_d, s1_sign_small_q;
  logic            s1_sign_big_d,   s1_sign_big_q;
  logic            s1_tie_d,        s1_tie_q;
  logic            s1_small_zero_d, s1_small_zero_q;
  logic            s1_valid_d,      s1_valid_q;

  // Stage-2 registers (module outputs)
  logic            sign_result_d,  sign_result_q;
  logic            valid_2_d,      valid_2_q;
  logic            signs_equal_d,  signs_equal_q;
  logic [E-1:0]    exp_b_2_d,      exp_b_2_q;
  logic [S:0]      sig_b_2_d,      sig_b_2_q;
  logic [S:0]      denorm_a_2_d,   denorm_a_2_q;
  logic            bso_2_d,        bso_2_q;
  logic            underflow_2_d,  underflow_2_q;

  logic [S:0]      shifted_sig;
  logic            shifted_bso;
  logic            shifted_underflow;

  // Denormals are flushed: a zero exponent clears the mantissa before the
  // compare, so every encoding with exponent 0 orders as an exact zero.
  always_comb begin
    sign_a = operand_a[OVERALL_BITS-1];
    sign_b = operand_b[OVERALL_BITS-1];
    exp_a  = operand_a[OVERALL_BITS-2 -: E];
    exp_b  = operand_b[OVERALL_BITS-2 -: E];
    man_a  = (exp_a != '0) ? operand_a[S-1:0] : '0;
    man_b  = (exp_b != '0) ? operand_b[S-1:0] : '0;
    mag_a  = {exp_a, man_a};
    mag_b  = {exp_b, man_b};
  end

  always_comb begin
    swap_sel        = (mag_a > mag_b) ? SEL_A_LARGER : SEL_B_LARGER;
    s1_sig_big_d    = {(exp_b != '0), man_b};
    s1_sig_small_d  = {(exp_a != '0), man_a};
    s1_exp_big_d    = exp_b;
    exp_small       = exp_a;
    s1_sign_big_d   = sign_b;
    s1_sign_small_d = sign_a;
    if (swap_sel == SEL_A_LARGER) begin
      s1_sig_big_d    = {(exp_a != '0), man_a};
      s1_sig_small_d  = {(exp_b != '0), man_b};
      s1_exp_big_d    = exp_a;
      exp_small       = exp_b;
      s1_sign_big_d   = sign_a;
      s1_sign_small_d = sign_b;
    end
    s1_shift_d      = s1_exp_big_d - exp_small;
    s1_tie_d        = (mag_a == mag_b);
    s1_small_zero_d = (exp_small == '0);
    s1_valid_d      = data_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sig_small_q  <= '0;
      s1_sig_big_q    <= '0;
      s1_exp_big_q    <= '0;
      s1_shift_q      <= '0;
      s1_sign_small_q <= 1'b0;
      s1_sign_big_q   <= 1'b0;
      s1_tie_q        <= 1'b0;
      s1_small_zero_q <= 1'b0;
      s1_valid_q      <= 1'b0;
    end else begin
      s1_sig_small_q  <= s1_sig_small_d;
      s1_sig_big_q    <= s1_sig_big_d;
      s1_exp_big_q    <= s1_exp_big_d;
      s1_shift_q      <= s1_shift_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_tie_q        <= s1_tie_d;
      s1_small_zero_q <= s1_small_zero_d;
      s1_valid_q      <= s1_valid_d;
    end
  end

  flp_adder_align_swap_shifter #(
    .SIG_W      (S + 1),
    .SHIFT_W    (E),
    .SHIFT_LIMIT(SHIFT_LIMIT)
  ) u_shifter (
    .sig_in         (s1_sig_small_q),
    .shift          (s1_shift_q),
    .force_zero     (s1_small_zero_q),
    .sig_out        (shifted_sig),
    .bit_shifted_out(shifted_bso),
    .underflow      (shifted_underflow)
  );

  // Exact cancellation (equal magnitudes, opposite signs) yields +0.
  always_comb begin
    sign_result_d = s1_sign_big_q;
    if (s1_tie_q && (s1_sign_small_q != s1_sign_big_q)) begin
      sign_result_d = 1'b0;
    end
    valid_2_d     = s1_valid_q;
    signs_equal_d = ~(s1_sign_small_q ^ s1_sign_big_q);
    exp_b_2_d     = s1_exp_big_q;
    sig_b_2_d     = s1_sig_big_q;
    denorm_a_2_d  = shifted_sig;
    bso_2_d       = shifted_bso;
    underflow_2_d = shifted_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_result_q <= 1'b0;
      valid_2_q     <= 1'b0;
      signs_equal_q <= 1'b0;
      exp_b_2_q     <= '0;
      sig_b_2_q     <= '0;
      denorm_a_2_q  <= '0;
      bso_2_q       <= 1'b0;
      underflow_2_q <= 1'b0;
    end else begin
      sign_result_q <= sign_result_d;
      valid_2_q     <= valid_2_d;
      signs_equal_q <= signs_equal_d;
      exp_b_2_q     <= exp_b_2_d;
      sig_b_2_q     <= sig_b_2_d;
      denorm_a_2_q  <= denorm_a_2_d;
      bso_2_q       <= bso_2_d;
      underflow_2_q <= underflow_2_d;
    end
  end

  assign sign_result_2DP          = sign_result_q;
  assign data_valid_2DP           = valid_2_q;
  assign signs_equal_2DP          = signs_equal_q;
  assign exponent_b_2DP           = exp_b_2_q;
  assign significant_b_2DP        = sig_b_2_q;
  assign denorm_significant_a_2DP = denorm_a_2_q;
  assign bit_shifted_out_2DP      = bso_2_q;
  assign denorm_underflow_2DP     = underflow_2_q;

endmodule

// File: tb/tb_flp_adder_align_swap.sv
// Bench for the FP adder align/swap front end: table vectors, random vectors
// against a bit-serial reference model, and a mid-stream reset sequence.
module tb_flp_adder_align_swap;

  localparam int RW = 60;  // {sign, signs_equal, exp_b[8], sig_b[24], denorm[24], bso, uf}

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] operand_a, operand_b;
  logic        data_valid;
  logic        sign_result_2DP, data_valid_2DP, signs_equal_2DP;
  logic [7:0]  exponent_b_2DP;
  logic [23:0] significant_b_2DP, denorm_significant_a_2DP;
  logic        bit_shifted_out_2DP, denorm_underflow_2DP;

  always #5 clk = ~clk;

  flp_adder_align_swap #(
    .EXPONENT_BITS   (8),
    .SIGNIFICANT_BITS(23)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .operand_a               (operand_a),
    .operand_b               (operand_b),
    .data_valid              (data_valid),
    .sign_result_2DP         (sign_result_2DP),
    .data_valid_2DP          (data_valid_2DP),
    .signs_equal_2DP         (signs_equal_2DP),
    .exponent_b_2DP          (exponent_b_2DP),
    .significant_b_2DP       (significant_b_2DP),
    .denorm_significant_a_2DP(denorm_significant_a_2DP),
    .bit_shifted_out_2DP     (bit_shifted_out_2DP),
    .denorm_underflow_2DP    (denorm_underflow_2DP)
  );

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t          vecs[13];
  logic [RW-1:0] exp_q[$];
  int            due_q[$];
  int            checks = 0;
  int            errors = 0;
  int            ncyc   = 0;
  logic [RW-1:0] act;

  assign act = {sign_result_2DP, signs_equal_2DP, exponent_b_2DP, significant_b_2DP,
                denorm_significant_a_2DP, bit_shifted_out_2DP, denorm_underflow_2DP};

  function automatic logic [RW-1:0] pack_exp(input logic sgn, input logic se,
                                             input logic [7:0] e, input logic [23:0] sb,
                                             input logic [23:0] den, input logic bso,
                                             input logic uf);
    return {sgn, se, e, sb, den, bso, uf};
  endfunction

  // Reference: shift one bit at a time, remembering the last bit dropped.
  function automatic logic [RW-1:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, e_big, e_small;
    logic [22:0] ma, mb;
    logic [23:0] s_big, s_small, den;
    logic        sa, sb, sign_big, tie, last, uf, sgn;
    int          d;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 23'd0 : a[22:0];
    mb = (eb == 8'd0) ? 23'd0 : b[22:0];
    sa = a[31];
    sb = b[31];
    tie = ({ea, ma} == {eb, mb});
    if ({ea, ma} > {eb, mb}) begin
      e_big = ea; s_big = {(ea != 8'd0), ma}; sign_big = sa;
      e_small = eb; s_small = {(eb != 8'd0), mb};
    end else begin
      e_big = eb; s_big = {(eb != 8'd0), mb}; sign_big = sb;
      e_small = ea; s_small = {(ea != 8'd0), ma};
    end
    d = int'(e_big) - int'(e_small);
    den = s_small;
    last = 1'b0;
    for (int i = 0; i < d && i < 26; i++) begin
      last = den[0];
      den  = den >> 1;
    end
    uf = (d >= 25) || (e_small == 8'd0);
    if (uf) begin
      den  = 24'd0;
      last = 1'b0;
    end
    sgn = (tie && (sa != sb)) ? 1'b0 : sign_big;
    return {sgn, ~(sa ^ sb), e_big, s_big, den, last, uf};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, ncyc);
    end
  endtask

  task automatic monitor();
    logic [RW-1:0] e;
    int            due;
    if (data_valid_2DP === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got outputs %h expected no valid output (cycle %0d)", act, ncyc);
      end else begin
        e   = exp_q.pop_front();
        due = due_q.pop_front();
        check("result", act, e);
        check("latency", RW'(ncyc), RW'(due));
      end
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v,
                      input logic push, input logic [RW-1:0] e);
    @(negedge clk);
    ncyc++;
    monitor();
    operand_a  = a;
    operand_b  = b;
    data_valid = v;
    if (v && push) begin
      exp_q.push_back(e);
      due_q.push_back(ncyc + 2);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  re;
    logic        rv;

    rst        = 1'b1;
    operand_a  = '0;
    operand_b  = '0;
    data_valid = 1'b0;
    #1;
    check("reset_outputs", act, '0);
    check("reset_valid", RW'(data_valid_2DP), '0);

    vecs[0]  = '{32'h3F800000, 32'h40000000, pack_exp(0, 1, 8'h80, 24'h800000, 24'h400000, 0, 0)};
    vecs[1]  = '{32'h3F800001, 32'h40000000, pack_exp(0, 1, 8'h80, 24'h800000, 24'h400000, 1, 0)};
    vecs[2]  = '{32'h3F800001, 32'h40800000, pack_exp(0, 1, 8'h81, 24'h800000, 24'h200000, 0, 0)};
    vecs[3]  = '{32'h3F800000, 32'hBF800000, pack_exp(0, 0, 8'h7F, 24'h800000, 24'h800000, 0, 0)};
    vecs[4]  = '{32'h3F800000, 32'h4B800000, pack_exp(0, 1, 8'h97, 24'h800000, 24'h000000, 1, 0)};
    vecs[5]  = '{32'h3F800000, 32'h4C000000, pack_exp(0, 1, 8'h98, 24'h800000, 24'h000000, 0, 1)};
    vecs[6]  = '{32'h00000000, 32'hC0400000, pack_exp(1, 0, 8'h80, 24'hC00000, 24'h000000, 0, 1)};
    vecs[7]  = '{32'h00000001, 32'hC0400000, pack_exp(1, 0, 8'h80, 24'hC00000, 24'h000000, 0, 1)};
    vecs[8]  = '{32'h40000000, 32'h3F800000, pack_exp(0, 1, 8'h80, 24'h800000, 24'h400000, 0, 0)};
    vecs[9]  = '{32'hC0000000, 32'h3F800000, pack_exp(1, 0, 8'h80, 24'h800000, 24'h400000, 0, 0)};
    vecs[10] = '{32'h80000000, 32'h00000000, pack_exp(0, 0, 8'h00, 24'h000000, 24'h000000, 0, 1)};
    vecs[11] = '{32'h3F800001, 32'h4B000000, pack_exp(0, 1, 8'h96, 24'h800000, 24'h000001, 0, 0)};
    vecs[12] = '{32'h7F800000, 32'h7F7FFFFF, pack_exp(0, 1, 8'hFF, 24'h800000, 24'h7FFFFF, 1, 0)};

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i].a, vecs[i].b, 1'b1, 1'b1, vecs[i].exp);

    // Random pairs with exponents close together so all shift ranges occur.
    for (int i = 0; i < 60; i++) begin
      re = 8'($urandom_range(0, 254));
      ra = {1'($urandom_range(0, 1)), re, 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 27) + re), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) rb[30:23] = 8'd0;
      if ($urandom_range(0, 1) == 1) begin
        {ra, rb} = {rb, ra};
      end
      rv = ($urandom_range(0, 4) != 0);
      step(ra, rb, rv, 1'b1, model(ra, rb));
    end
    repeat (3) step('0, '0, 1'b0, 1'b0, '0);

    // Back-to-back pairs with a one-cycle reset after the third is sampled.
    step(vecs[0].a, vecs[0].b, 1'b1, 1'b1, vecs[0].exp);
    step(vecs[1].a, vecs[1].b, 1'b1, 1'b1, vecs[1].exp);
    step(vecs[2].a, vecs[2].b, 1'b1, 1'b1, vecs[2].exp);
    step(vecs[3].a, vecs[3].b, 1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_outputs", act, '0);
    check("midreset_valid", RW'(data_valid_2DP), '0);
    exp_q.delete();
    due_q.delete();
    step(vecs[3].a, vecs[3].b, 1'b1, 1'b1, vecs[3].exp);
    rst = 1'b0;
    step(vecs[4].a, vecs[4].b, 1'b1, 1'b1, vecs[4].exp);
    repeat (4) step('0, '0, 1'b0, 1'b0, '0);

    check("drain_empty", RW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
